// File: rtl/ecall_unit.sv
// Environment-call sequencer: IDLE -> DRAIN -> CALL -> WB -> FLUSH. rf_we is asserted 2 cycles after DRAIN exits and flush 3 cycles after; stall is held throughout.
// DRAIN waits on mem_idle, bounded by DRAIN_TIMEOUT. do_ecall is a synthesizable stand-in for the host call. Optional ECALL_EXIT_EN: exit (a7==93) halts the core.
module ecall_unit #(
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_ARGS      = 8,
    parameter int DRAIN_TIMEOUT = 255,
    parameter int RF_ADDR_W     = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           trigger,
    input  logic [DATA_WIDTH-1:0]          epc,
    input  logic [NUM_ARGS*DATA_WIDTH-1:0] args,
    input  logic                           mem_idle,
    output logic                           busy,
    output logic                           stall,
    output logic                           rf_we,
    output logic [RF_ADDR_W-1:0]           rf_waddr,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    output logic                           flush,
    output logic [DATA_WIDTH-1:0]          redirect_pc,
    output logic                           drain_timeout,
    output logic                           halt
);
    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int DW    = DATA_WIDTH;

    generate
        if (NUM_ARGS != 8) begin : g_bad_num_args
            $error("ecall_unit: NUM_ARGS must be 8");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_CALL, S_WB, S_FLUSH} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [NUM_ARGS*DW-1:0]     args_q;
    logic [DW-1:0]              epc_q;
    logic [CNT_W-1:0]           cnt;
    logic                       timeout_set;
    logic                       is_exit;
    logic                       halt_q;
    logic                       accept;

    // Host-call hook: call number in a7, arguments a0..a6.
    function automatic logic [DW-1:0] do_ecall(
        input logic [DW-1:0] num,
        input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
        input logic [DW-1:0] a3, input logic [DW-1:0] a4, input logic [DW-1:0] a5,
        input logic [DW-1:0] a6
    );
        return num ^ (a0 + a1 + a2 + a3 + a4 + a5 + a6);
    endfunction

`ifdef ECALL_EXIT_EN
    assign is_exit = (args_q[7*DW +: DW] == DW'(93));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            halt_q <= 1'b0;
        else if (state == S_CALL && is_exit)
            halt_q <= 1'b1;
    end
`else
    assign is_exit = 1'b0;
    assign halt_q  = 1'b0;
`endif

    // A halted core parks in IDLE and never accepts another call.
    assign accept = trigger && !halt_q;

    always_comb begin
        state_nxt   = state;
        timeout_set = 1'b0;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (mem_idle) begin
                    state_nxt = S_CALL;
                end else if (cnt == CNT_W'(DRAIN_TIMEOUT)) begin
                    state_nxt   = S_CALL;
                    timeout_set = 1'b1;
                end
            end
            S_CALL:  state_nxt = is_exit ? S_FLUSH : S_WB;
            S_WB:    state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            args_q        <= '0;
            epc_q         <= '0;
            cnt           <= '0;
            drain_timeout <= 1'b0;
            rf_wdata      <= '0;
            redirect_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && accept) begin
                args_q <= args;
                epc_q  <= epc;
            end
            cnt <= (state == S_DRAIN) ? cnt + 1'b1 : '0;
            if (timeout_set)
                drain_timeout <= 1'b1;
            // Exit calls never write back, so rf_wdata keeps its previous value.
            if (state == S_CALL && !is_exit)
                rf_wdata <= do_ecall(args_q[7*DW +: DW],
                                     args_q[0*DW +: DW], args_q[1*DW +: DW],
                                     args_q[2*DW +: DW], args_q[3*DW +: DW],
                                     args_q[4*DW +: DW], args_q[5*DW +: DW],
                                     args_q[6*DW +: DW]);
            if (state_nxt == S_FLUSH)
                redirect_pc <= epc_q + DW'(4);
        end
    end

    assign busy     = (state != S_IDLE) || halt_q;
    assign stall    = busy;
    assign rf_we    = (state == S_WB);
    assign rf_waddr = RF_ADDR_W'(10);
    assign flush    = (state == S_FLUSH);
    assign halt     = halt_q;

endmodule
